// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width constant and opcode encoding for the alu
package alu_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_NOT = 3'd7
    } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational add/subtract with carry-in, carry/borrow-out and signed overflow
module alu_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic [WIDTH:0] full;

    always_comb begin
        full       = '0;
        overflow_o = 1'b0;
        if (sub_i) begin
            // A negative 9-bit difference wraps with bit WIDTH set, which is exactly the borrow
            full       = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
            overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (full[WIDTH-1] != a_i[WIDTH-1]);
        end else begin
            full       = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
            overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (full[WIDTH-1] != a_i[WIDTH-1]);
        end
        sum_o   = full[WIDTH-1:0];
        carry_o = full[WIDTH];
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 8-bit ALU with flags; define ALU_SHIFT_EN to build the SHL/SHR ops
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             out_valid
);

    alu_op_t          op_e;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0] res_n;
    logic             cout_n;
    logic             ovf_n;

    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    assign op_e = alu_op_t'(op);

    alu_addsub u_addsub (
        .a_i        (a),
        .b_i        (b),
        .cin_i      (cin),
        .sub_i      (op_e == ALU_SUB),
        .sum_o      (as_sum),
        .carry_o    (as_carry),
        .overflow_o (as_ovf)
    );

    always_comb begin
        res_n  = a;
        cout_n = 1'b0;
        ovf_n  = 1'b0;
        case (op_e)
            ALU_ADD, ALU_SUB: begin
                res_n  = as_sum;
                cout_n = as_carry;
                ovf_n  = as_ovf;
            end
            ALU_AND: res_n = a & b;
            ALU_OR:  res_n = a | b;
            ALU_XOR: res_n = a ^ b;
`ifdef ALU_SHIFT_EN
            ALU_SHL: {cout_n, res_n} = {a, cin};
            ALU_SHR: {res_n, cout_n} = {cin, a};
`else
            ALU_SHL, ALU_SHR: res_n = a;
`endif
            ALU_NOT: res_n = ~a;
            default: res_n = a;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d   = res_n;
            cout_d     = cout_n;
            zero_d     = (res_n == '0);
            negative_d = res_n[WIDTH-1];
            overflow_d = ovf_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu; honours ALU_SHIFT_EN for the shift expectations
module tb_alu;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       cin = 1'b0;
    logic [7:0] result;
    logic       cout, zero, negative, overflow, out_valid;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t last = '0;

    always #5 clk = ~clk;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input logic ci);
        exp_t e;
        int   s;
        e = '0;
        case (o)
            3'd0: begin
                s   = int'(x) + int'(y) + int'(ci);
                e.r = s[7:0];
                e.c = (s > 255);
                e.v = (x[7] == y[7]) && (e.r[7] != x[7]);
            end
            3'd1: begin
                s   = int'(x) - int'(y) - int'(ci);
                e.r = s[7:0];
                e.c = (int'(x) < int'(y) + int'(ci));
                e.v = (x[7] != y[7]) && (e.r[7] != x[7]);
            end
            3'd2: e.r = x & y;
            3'd3: e.r = x | y;
            3'd4: e.r = x ^ y;
`ifdef ALU_SHIFT_EN
            3'd5: begin e.r = {x[6:0], ci}; e.c = x[7]; end
            3'd6: begin e.r = {ci, x[7:1]}; e.c = x[0]; end
`else
            3'd5, 3'd6: e.r = x;
`endif
            default: e.r = ~x;
        endcase
        e.z = (e.r == 8'd0);
        e.n = e.r[7];
        return e;
    endfunction

    task automatic req(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic ci);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        cin      = ci;
        sb.push_back(model(o, x, y, ci));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 8'($urandom);
            b        = 8'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("cout", 32'(cout), 32'(e.c));
                check("zero", 32'(zero), 32'(e.z));
                check("negative", 32'(negative), 32'(e.n));
                check("overflow", 32'(overflow), 32'(e.v));
                last = e;
            end
        end else begin
            check("hold", 32'({result, cout, zero, negative, overflow}), 32'(last));
        end
    end

    initial begin
        #2;
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'({cout, zero, negative, overflow}), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        req(3'd0, 8'd37, 8'd5, 1'b0);
        req(3'd0, 8'd37, 8'd5, 1'b1);
        req(3'd0, 8'd255, 8'd1, 1'b0);
        idle(1);
        req(3'd0, 8'd127, 8'd1, 1'b0);
        req(3'd1, 8'd5, 8'd7, 1'b0);
        req(3'd1, 8'h80, 8'd1, 1'b0);
        idle(2);
        req(3'd2, 8'hF0, 8'h3C, 1'b0);
        req(3'd4, 8'hFF, 8'hFF, 1'b0);
        req(3'd5, 8'h81, 8'h00, 1'b1);
        req(3'd6, 8'h01, 8'h00, 1'b1);
        req(3'd3, 8'h0F, 8'h30, 1'b0);
        req(3'd7, 8'h5A, 8'h00, 1'b0);
        req(3'd1, 8'd0, 8'd0, 1'b1);
        idle(3);

        // reset lands after the request edge, before the result would be consumed
        req(3'd0, 8'd10, 8'd20, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_flags", 32'({cout, zero, negative, overflow}), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                req(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idle(1);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        idle(2);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
